// File: rtl/id_ex_stage_pkg.sv
// ----------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared CPU types for the ID/EX stage and its forwarding muxes.
//   Data / DataReg : XLEN-wide datapath values (combinational / registered)
//   Bool           : single-bit flag
//   RegAddr        : register-file address
//   ALUOp          : ALU operation encoding (ALU_ADD is the idle/reset op)
//   REG_ZERO       : address of the hard-wired zero register x0
// ----------------------------------------------------------------------------
package id_ex_stage_pkg;

    localparam int CPU_XLEN  = 32;
    localparam int CPU_REG_W = 5;

    typedef logic [CPU_XLEN-1:0]  Data;
    typedef logic [CPU_XLEN-1:0]  DataReg;
    typedef logic                 Bool;
    typedef logic [CPU_REG_W-1:0] RegAddr;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SLL  = 3'd1,
        ALU_SLT  = 3'd2,
        ALU_SLTU = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SRL  = 3'd5,
        ALU_OR   = 3'd6,
        ALU_AND  = 3'd7
    } ALUOp;

    localparam RegAddr REG_ZERO = '0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// ----------------------------------------------------------------------------
// fwd_mux
// Selects the most recent value of one source register for the EX stage.
//   rs           : source register address latched in ID/EX
//   reg_val      : register-file value latched in ID/EX
//   mem_rd/mem_fwd_en/mem_result : EX/MEM forwarding source (highest priority)
//   wb_rd/wb_reg_write/wb_result : MEM/WB forwarding source
//   fwd_val      : forwarded operand
// x0 is never forwarded, so writes to x0 in flight cannot leak a nonzero value.
// ----------------------------------------------------------------------------
module fwd_mux #(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rs,
    input  logic [XLEN-1:0]  reg_val,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_fwd_en,
    input  logic [XLEN-1:0]  mem_result,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write,
    input  logic [XLEN-1:0]  wb_result,
    output logic [XLEN-1:0]  fwd_val
);

    logic rs_nonzero;
    logic mem_hit;
    logic wb_hit;

    assign rs_nonzero = (rs != '0);
    assign mem_hit    = mem_fwd_en   && (mem_rd == rs) && rs_nonzero;
    assign wb_hit     = wb_reg_write && (wb_rd  == rs) && rs_nonzero;

    // EX/MEM is younger than MEM/WB, so it wins when both match
    always_comb begin
        fwd_val = reg_val;
        if (mem_hit) begin
            fwd_val = mem_result;
        end else if (wb_hit) begin
            fwd_val = wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register plus operand forwarding, directly ahead of the ALU.
//   clk, reset         : rising-edge clock, asynchronous active-high reset
//   id_*               : decoded instruction from the ID stage
//   mem_* / wb_*       : forwarding sources from EX/MEM and MEM/WB
//   flush              : kill the instruction entering EX (branch redirect)
//   stall_id           : load-use hazard, hold PC and IF/ID this cycle
//   ex_*               : registered instruction and forwarded ALU operands
// ----------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic [XLEN-1:0]  id_rs1_val,
    input  logic [XLEN-1:0]  id_rs2_val,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_a_pc,
    input  logic             id_b_imm,
    input  ALUOp             id_alu_op,
    input  logic             id_alu_mod,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_reg_write,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_fwd_en,
    input  logic [XLEN-1:0]  mem_result,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write,
    input  logic [XLEN-1:0]  wb_result,
    input  logic             flush,
    output logic             stall_id,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_a,
    output logic [XLEN-1:0]  ex_b,
    output ALUOp             ex_alu_op,
    output logic             ex_alu_mod,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [REG_W-1:0] ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic [XLEN-1:0]  ex_pc
);

    logic             valid_q;
    logic [XLEN-1:0]  pc_q;
    logic [REG_W-1:0] rs1_q;
    logic [REG_W-1:0] rs2_q;
    logic [REG_W-1:0] rd_q;
    logic [XLEN-1:0]  rs1_val_q;
    logic [XLEN-1:0]  rs2_val_q;
    logic [XLEN-1:0]  imm_q;
    logic             a_pc_q;
    logic             b_imm_q;
    ALUOp             alu_op_q;
    logic             alu_mod_q;
    logic             mem_read_q;
    logic             mem_write_q;
    logic             reg_write_q;
    logic [XLEN-1:0]  fwd_rs1;
    logic [XLEN-1:0]  fwd_rs2;

    // Load-use hazard: the load in EX has no data until MEM/WB, so a dependent
    // instruction in ID waits one cycle. Decode zeroes unused rs2, and the
    // rd!=0 term keeps that zero from ever matching.
    assign stall_id = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
                      ((id_rs1 == rd_q) || (id_rs2 == rd_q));

    // Pipeline register. Flush and stall both insert a bubble; the data
    // fields of a bubble are left stale because nothing downstream uses them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            imm_q       <= '0;
            a_pc_q      <= 1'b0;
            b_imm_q     <= 1'b0;
            alu_op_q    <= ALU_ADD;
            alu_mod_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (flush || stall_id) begin
            valid_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= id_valid;
            pc_q        <= id_pc;
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
            rd_q        <= id_rd;
            rs1_val_q   <= id_rs1_val;
            rs2_val_q   <= id_rs2_val;
            imm_q       <= id_imm;
            a_pc_q      <= id_a_pc;
            b_imm_q     <= id_b_imm;
            alu_op_q    <= id_alu_op;
            alu_mod_q   <= id_alu_mod;
            mem_read_q  <= id_mem_read;
            mem_write_q <= id_mem_write;
            reg_write_q <= id_reg_write;
        end
    end

    fwd_mux #(.XLEN(XLEN), .REG_W(REG_W)) u_fwd_rs1 (
        .rs           (rs1_q),
        .reg_val      (rs1_val_q),
        .mem_rd       (mem_rd),
        .mem_fwd_en   (mem_fwd_en),
        .mem_result   (mem_result),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .wb_result    (wb_result),
        .fwd_val      (fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .REG_W(REG_W)) u_fwd_rs2 (
        .rs           (rs2_q),
        .reg_val      (rs2_val_q),
        .mem_rd       (mem_rd),
        .mem_fwd_en   (mem_fwd_en),
        .mem_result   (mem_result),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .wb_result    (wb_result),
        .fwd_val      (fwd_rs2)
    );

    assign ex_valid      = valid_q;
    assign ex_a          = a_pc_q  ? pc_q  : fwd_rs1;
    assign ex_b          = b_imm_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ex_alu_op     = alu_op_q;
    assign ex_alu_mod    = alu_mod_q;
    assign ex_rd         = rd_q;
    assign ex_pc         = pc_q;

    // Side effects are gated so a bubble or reset can never write anything
    assign ex_reg_write  = valid_q && reg_write_q;
    assign ex_mem_read   = valid_q && mem_read_q;
    assign ex_mem_write  = valid_q && mem_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed, self-checking bench for id_ex_stage.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_val, id_rs2_val, id_imm;
    logic        id_a_pc, id_b_imm;
    ALUOp        id_alu_op;
    logic        id_alu_mod, id_mem_read, id_mem_write, id_reg_write;
    logic [4:0]  mem_rd;
    logic        mem_fwd_en;
    logic [31:0] mem_result;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_result;
    logic        flush;
    logic        stall_id, ex_valid;
    logic [31:0] ex_a, ex_b, ex_store_data, ex_pc;
    ALUOp        ex_alu_op;
    logic        ex_alu_mod;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;

    int vectors     = 0;
    int miscompares = 0;

    id_ex_stage #(.XLEN(32), .REG_W(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_rs1_val    (id_rs1_val),
        .id_rs2_val    (id_rs2_val),
        .id_imm        (id_imm),
        .id_a_pc       (id_a_pc),
        .id_b_imm      (id_b_imm),
        .id_alu_op     (id_alu_op),
        .id_alu_mod    (id_alu_mod),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .id_reg_write  (id_reg_write),
        .mem_rd        (mem_rd),
        .mem_fwd_en    (mem_fwd_en),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .flush         (flush),
        .stall_id      (stall_id),
        .ex_valid      (ex_valid),
        .ex_a          (ex_a),
        .ex_b          (ex_b),
        .ex_alu_op     (ex_alu_op),
        .ex_alu_mod    (ex_alu_mod),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_pc         (ex_pc)
    );

    always #5 clk = ~clk;

    // Hard stop in case a task never returns
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] timeout");
    end

    // Advance one rising edge and settle just past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return every stimulus input to an idle, no-instruction value
    task automatic idle_inputs();
        id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_val = 0; id_rs2_val = 0; id_imm = 0;
        id_a_pc = 0; id_b_imm = 0; id_alu_op = ALU_ADD; id_alu_mod = 0;
        id_mem_read = 0; id_mem_write = 0; id_reg_write = 0;
        mem_rd = 0; mem_fwd_en = 0; mem_result = 0;
        wb_rd = 0; wb_reg_write = 0; wb_result = 0;
        flush = 0;
    endtask

    // Put "LW x3, 0(x2)" on the decode inputs
    task automatic drive_lw_x3();
        idle_inputs();
        id_valid = 1; id_rs1 = 2; id_rd = 3; id_b_imm = 1;
        id_mem_read = 1; id_reg_write = 1; id_pc = 32'h40;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        #12;
        vectors++;
        if (ex_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_valid: got %b expected 0", ex_valid);
        end
        vectors++;
        if (ex_alu_op !== ALU_ADD) begin
            miscompares++;
            $display("[TB] FAIL reset_aluop: got %0d expected %0d", ex_alu_op, ALU_ADD);
        end
        reset = 0;
        tick();
        // Load in EX with a dependent instruction in ID, then reset mid-cycle
        drive_lw_x3();
        tick();
        id_rs1 = 3; id_rs2 = 1; id_rd = 4; id_b_imm = 0; id_mem_read = 0;
        #1;
        vectors++;
        if (stall_id !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_stall: got %b expected 1", stall_id);
        end
        #2;
        reset = 1;
        #1;
        vectors++;
        if ({ex_valid, ex_reg_write, stall_id} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got valid/rw/stall=%b expected 000",
                     {ex_valid, ex_reg_write, stall_id});
        end
        #1;
        reset = 0;
        idle_inputs();
        id_valid = 1; id_rd = 9; id_reg_write = 1; id_pc = 32'h80;
        tick();
        vectors++;
        if ({ex_valid, ex_reg_write, ex_rd, ex_pc} !== {1'b1, 1'b1, 5'd9, 32'h80}) begin
            miscompares++;
            $display("[TB] FAIL first_after_reset: got v=%b rw=%b rd=%0d pc=%h expected v=1 rw=1 rd=9 pc=00000080",
                     ex_valid, ex_reg_write, ex_rd, ex_pc);
        end
    endtask

    task automatic test_fwd_priority();
        idle_inputs();
        id_valid = 1; id_rs1 = 5; id_rs1_val = 32'h1; id_rs2 = 0; id_rs2_val = 32'h33;
        id_rd = 6; id_reg_write = 1;
        tick();
        mem_rd = 5; mem_fwd_en = 1; mem_result = 32'h10;
        wb_rd = 5; wb_reg_write = 1; wb_result = 32'h20;
        #1;
        vectors++;
        if (ex_a !== 32'h10) begin
            miscompares++;
            $display("[TB] FAIL fwd_mem_priority: got %h expected 00000010", ex_a);
        end
        vectors++;
        if (ex_b !== 32'h33) begin
            miscompares++;
            $display("[TB] FAIL fwd_rs2_x0_unforwarded: got %h expected 00000033", ex_b);
        end
        mem_fwd_en = 0;
        #1;
        vectors++;
        if (ex_a !== 32'h20) begin
            miscompares++;
            $display("[TB] FAIL fwd_wb: got %h expected 00000020", ex_a);
        end
        wb_rd = 4;
        #1;
        vectors++;
        if (ex_a !== 32'h1) begin
            miscompares++;
            $display("[TB] FAIL fwd_none: got %h expected 00000001", ex_a);
        end
    endtask

    task automatic test_x0_guard();
        idle_inputs();
        id_valid = 1; id_rs1 = 0; id_rs1_val = 0; id_rd = 7; id_reg_write = 1;
        tick();
        mem_rd = 0; mem_fwd_en = 1; mem_result = 32'hDEAD;
        wb_rd = 0; wb_reg_write = 1; wb_result = 32'hBEEF;
        #1;
        vectors++;
        if (ex_a !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL x0_guard: got %h expected 00000000", ex_a);
        end
    endtask

    task automatic test_imm_pc();
        idle_inputs();
        id_valid = 1; id_a_pc = 1; id_pc = 32'h100; id_b_imm = 1; id_imm = 32'hFFFFF000;
        id_rs1 = 1; id_rs1_val = 32'h5; id_rs2 = 2; id_rs2_val = 32'h0;
        id_alu_op = ALU_SRL; id_alu_mod = 1; id_mem_write = 1;
        tick();
        mem_rd = 2; mem_fwd_en = 1; mem_result = 32'h7;
        #1;
        vectors++;
        if ({ex_a, ex_b, ex_store_data} !== {32'h100, 32'hFFFFF000, 32'h7}) begin
            miscompares++;
            $display("[TB] FAIL imm_pc: got a=%h b=%h sd=%h expected a=00000100 b=fffff000 sd=00000007",
                     ex_a, ex_b, ex_store_data);
        end
        vectors++;
        if ({ex_alu_op, ex_alu_mod, ex_mem_write, ex_reg_write} !== {ALU_SRL, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL imm_pc_ctrl: got op=%0d mod=%b mw=%b rw=%b expected op=5 mod=1 mw=1 rw=0",
                     ex_alu_op, ex_alu_mod, ex_mem_write, ex_reg_write);
        end
    endtask

    task automatic test_load_use();
        drive_lw_x3();
        tick();
        // ADD x4, x3, x1
        idle_inputs();
        id_valid = 1; id_rs1 = 3; id_rs2 = 1; id_rd = 4; id_reg_write = 1; id_rs1_val = 0;
        #1;
        vectors++;
        if ({stall_id, ex_mem_read} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL load_use_stall: got stall/mr=%b expected 11", {stall_id, ex_mem_read});
        end
        tick();
        vectors++;
        if ({ex_valid, ex_reg_write, ex_mem_read, stall_id} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL load_use_bubble: got v/rw/mr/stall=%b expected 0000",
                     {ex_valid, ex_reg_write, ex_mem_read, stall_id});
        end
        wb_rd = 3; wb_reg_write = 1; wb_result = 32'h55;
        tick();
        vectors++;
        if ({ex_valid, ex_a, ex_rd, stall_id} !== {1'b1, 32'h55, 5'd4, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL load_use_resume: got v=%b a=%h rd=%0d stall=%b expected v=1 a=00000055 rd=4 stall=0",
                     ex_valid, ex_a, ex_rd, stall_id);
        end
    endtask

    task automatic test_back_to_back();
        // Dependency through rs2 also stalls
        drive_lw_x3();
        tick();
        idle_inputs();
        id_valid = 1; id_rs1 = 1; id_rs2 = 3; id_rd = 4; id_reg_write = 1;
        #1;
        vectors++;
        if (stall_id !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rs2_hazard: got %b expected 1", stall_id);
        end
        tick();
        // Load to x0 never creates a hazard, even against a zero rs2
        idle_inputs();
        id_valid = 1; id_rs1 = 2; id_rd = 0; id_b_imm = 1; id_mem_read = 1; id_reg_write = 1;
        tick();
        idle_inputs();
        id_valid = 1; id_rs1 = 0; id_rs2 = 0; id_rd = 5; id_reg_write = 1;
        #1;
        vectors++;
        if (stall_id !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_x0_no_hazard: got %b expected 0", stall_id);
        end
        // Invalid instruction in ID does not stall
        drive_lw_x3();
        tick();
        idle_inputs();
        id_valid = 0; id_rs1 = 3;
        #1;
        vectors++;
        if (stall_id !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL invalid_id_no_hazard: got %b expected 0", stall_id);
        end
        tick();
    endtask

    task automatic test_flush_hazard();
        drive_lw_x3();
        tick();
        idle_inputs();
        id_valid = 1; id_rs1 = 3; id_rd = 4; id_reg_write = 1;
        flush = 1;
        #1;
        vectors++;
        if (stall_id !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL flush_stall_visible: got %b expected 1", stall_id);
        end
        tick();
        vectors++;
        if ({ex_valid, ex_reg_write} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL flush_bubble: got v/rw=%b expected 00", {ex_valid, ex_reg_write});
        end
        idle_inputs();
        id_valid = 1; id_rs1 = 1; id_rs1_val = 32'h99; id_rd = 7; id_reg_write = 1;
        id_alu_op = ALU_OR; id_pc = 32'h200;
        tick();
        vectors++;
        if ({ex_valid, ex_reg_write, ex_rd, ex_a, ex_pc} !== {1'b1, 1'b1, 5'd7, 32'h99, 32'h200}) begin
            miscompares++;
            $display("[TB] FAIL flush_redirect: got v=%b rw=%b rd=%0d a=%h pc=%h expected v=1 rw=1 rd=7 a=00000099 pc=00000200",
                     ex_valid, ex_reg_write, ex_rd, ex_a, ex_pc);
        end
        // Flush alone also kills a valid instruction
        flush = 1;
        tick();
        vectors++;
        if (ex_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_plain: got %b expected 0", ex_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fwd_priority();
        test_x0_guard();
        test_imm_pc();
        test_load_use();
        test_back_to_back();
        test_flush_hazard();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
